// File: rtl/phase_sequencer_pkg.sv
// Shared encodings for the phase sequencer and the switch-control FSM.
// State and phase codes plus small state-class helpers.
package phase_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COMMUTE  = 3'd1,
        ST_DWELL    = 3'd2,
        ST_FAULT    = 3'd3,
        ST_COOLDOWN = 3'd4
    } seq_state_e;

    typedef enum logic [1:0] {
        PH_OFF = 2'd0,
        PH_A   = 2'd1,
        PH_B   = 2'd2,
        PH_C   = 2'd3
    } phase_e;

    function automatic logic is_busy_state(seq_state_e s);
        return s != ST_IDLE;
    endfunction

    function automatic logic is_fault_state(seq_state_e s);
        return (s == ST_FAULT) || (s == ST_COOLDOWN);
    endfunction

endpackage

// File: rtl/phase_seq_timer.sv
// Loadable saturating down-counter shared by all timed sequencer states.
// A load takes priority; otherwise the count steps toward zero and holds there.
module phase_seq_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/phase_sequencer.sv
// Phase-change scheduler in front of the switch FSM: handshake, settle/dwell timing, short handling.
// Define PHASE_SEQ_RETRY_EN to add the COOLDOWN state with automatic retries before lockout.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int unsigned COMMUTE_CYCLES  = 4,
    parameter int unsigned DWELL_CYCLES    = 16,
`ifdef PHASE_SEQ_RETRY_EN
    parameter int unsigned COOLDOWN_CYCLES = 64,
    parameter int unsigned MAX_RETRIES     = 3,
`endif
    parameter int unsigned CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_phase,
    output logic       req_ready,
    output logic       fsm_start,
    output logic [1:0] fsm_load,
    input  logic       fsm_short,
    input  logic       fault_clr,
    output logic [1:0] active_phase,
    output logic       busy,
    output logic       fault
);

    localparam logic [CNT_W-1:0] COMMUTE_LD = CNT_W'(COMMUTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LD   = CNT_W'(DWELL_CYCLES - 1);
`ifdef PHASE_SEQ_RETRY_EN
    localparam logic [CNT_W-1:0] COOLDOWN_LD = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam int unsigned      RETRY_W     = $clog2(MAX_RETRIES + 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    logic [RETRY_W-1:0] retry_q, retry_d;
`endif

    seq_state_e       state_q, state_d;
    logic             run_q;
    logic             start_q, start_d;
    logic [1:0]       load_q, load_d;
    logic [1:0]       active_q, active_d;
    logic [1:0]       saved_q, saved_d;
    logic             busy_q, fault_q;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    phase_seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // run_q keeps ready low for the first cycle out of reset
    assign req_ready = run_q && (state_q == ST_IDLE);

    always_comb begin
        state_d  = state_q;
        start_d  = 1'b0;
        load_d   = load_q;
        active_d = active_q;
        saved_d  = saved_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
`ifdef PHASE_SEQ_RETRY_EN
        retry_d  = retry_q;
`endif
        case (state_q)
            ST_IDLE, ST_COMMUTE, ST_DWELL: begin
                if (fsm_short) begin
                    state_d  = ST_FAULT;
                    start_d  = 1'b1;
                    load_d   = PH_OFF;
                    active_d = PH_OFF;
                    tmr_load = 1'b1;
                end else if (state_q == ST_IDLE) begin
                    if (req_valid && req_ready && (req_phase != active_q)) begin
                        state_d  = ST_COMMUTE;
                        start_d  = 1'b1;
                        load_d   = req_phase;
                        saved_d  = req_phase;
                        tmr_load = 1'b1;
                        tmr_val  = COMMUTE_LD;
                    end
                end else if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (state_q == ST_COMMUTE) begin
                        state_d  = ST_DWELL;
                        active_d = saved_q;
                        tmr_val  = DWELL_LD;
                    end else begin
                        state_d = ST_IDLE;
`ifdef PHASE_SEQ_RETRY_EN
                        retry_d = '0;
`endif
                    end
                end
            end
            ST_FAULT: begin
                if (fault_clr && !fsm_short) begin
                    state_d  = ST_IDLE;
                    tmr_load = 1'b1;
`ifdef PHASE_SEQ_RETRY_EN
                    retry_d  = '0;
                end else if (retry_q < RETRY_MAX) begin
                    state_d  = ST_COOLDOWN;
                    tmr_load = 1'b1;
                    tmr_val  = COOLDOWN_LD;
`endif
                end
            end
`ifdef PHASE_SEQ_RETRY_EN
            ST_COOLDOWN: begin
                if (fault_clr) begin
                    state_d  = ST_IDLE;
                    retry_d  = '0;
                    tmr_load = 1'b1;
                end else if (tmr_zero) begin
                    retry_d  = retry_q + 1'b1;
                    tmr_load = 1'b1;
                    if (fsm_short) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_COMMUTE;
                        start_d = 1'b1;
                        load_d  = saved_q;
                        tmr_val = COMMUTE_LD;
                    end
                end
            end
`endif
            default: begin
                state_d  = ST_IDLE;
                tmr_load = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            run_q    <= 1'b0;
            start_q  <= 1'b0;
            load_q   <= PH_OFF;
            active_q <= PH_OFF;
            saved_q  <= PH_OFF;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
`ifdef PHASE_SEQ_RETRY_EN
            retry_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            run_q    <= 1'b1;
            start_q  <= start_d;
            load_q   <= load_d;
            active_q <= active_d;
            saved_q  <= saved_d;
            busy_q   <= is_busy_state(state_d);
            fault_q  <= is_fault_state(state_d);
`ifdef PHASE_SEQ_RETRY_EN
            retry_q  <= retry_d;
`endif
        end
    end

    assign fsm_start    = start_q;
    assign fsm_load     = load_q;
    assign active_phase = active_q;
    assign busy         = busy_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed steps followed by random traffic, against a
// timeline model that predicts when pulses, phase confirmations and ready occur.
module tb_phase_sequencer;

    localparam int C   = 4;
    localparam int D   = 16;
    localparam int INF = 32'h3fff_ffff;
`ifdef PHASE_SEQ_RETRY_EN
    localparam int CD   = 64;
    localparam int MAXR = 3;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_phase = 2'd0;
    logic       fsm_short = 1'b0;
    logic       fault_clr = 1'b0;
    logic       req_ready, fsm_start, busy, fault;
    logic [1:0] fsm_load, active_phase;

    phase_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_phase    (req_phase),
        .req_ready    (req_ready),
        .fsm_start    (fsm_start),
        .fsm_load     (fsm_load),
        .fsm_short    (fsm_short),
        .fault_clr    (fault_clr),
        .active_phase (active_phase),
        .busy         (busy),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Model: times (cycle numbers) at which visible events happen
    bit         m_run, m_fault;
    int         m_idle_at, m_pulse_at, m_active_at, m_cool_start, m_decide_at;
    logic [1:0] m_load, m_active, m_next;
`ifdef PHASE_SEQ_RETRY_EN
    int         m_retry;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic [1:0] exp_active(input int k);
        return (k >= m_active_at) ? m_next : m_active;
    endfunction

    task automatic model_edge(input logic v, input logic [1:0] ph, input logic sh,
                              input logic clr, input logic rs);
        int p;
        bit idle_prev, in_cool;
        p = cyc - 1;
        if (!rs) begin
            m_run = 0; m_fault = 0; m_idle_at = cyc; m_pulse_at = -1;
            m_active_at = INF; m_load = 0; m_active = 0; m_next = 0;
            m_cool_start = INF; m_decide_at = INF;
`ifdef PHASE_SEQ_RETRY_EN
            m_retry = 0;
`endif
            return;
        end
        idle_prev = m_run && !m_fault && (p >= m_idle_at);
        m_run = 1;
        if (!m_fault) begin
            if (sh) begin
                m_fault = 1; m_load = 0; m_pulse_at = cyc;
                m_active = 0; m_active_at = INF; m_idle_at = INF;
                m_cool_start = INF; m_decide_at = INF;
`ifdef PHASE_SEQ_RETRY_EN
                if (idle_prev) m_retry = 0;
                if (m_retry < MAXR) begin
                    m_cool_start = cyc + 1; m_decide_at = cyc + 1 + CD;
                end
`endif
            end else if (idle_prev && v && (ph != exp_active(p))) begin
                m_active = exp_active(p); m_next = ph; m_load = ph;
                m_pulse_at = cyc; m_active_at = cyc + C; m_idle_at = cyc + C + D;
            end
        end else begin
            in_cool = (p >= m_cool_start) && (p < m_decide_at);
            if (clr && (in_cool || !sh)) begin
                m_fault = 0; m_idle_at = cyc; m_cool_start = INF; m_decide_at = INF;
`ifdef PHASE_SEQ_RETRY_EN
                m_retry = 0;
`endif
            end else if (cyc == m_decide_at) begin
`ifdef PHASE_SEQ_RETRY_EN
                m_retry++;
                if (sh) begin
                    m_cool_start = INF; m_decide_at = INF;
                    if (m_retry < MAXR) begin
                        m_cool_start = cyc + 1; m_decide_at = cyc + 1 + CD;
                    end
                end else begin
                    m_fault = 0; m_load = m_next; m_pulse_at = cyc; m_active = 0;
                    m_active_at = cyc + C; m_idle_at = cyc + C + D;
                    m_cool_start = INF; m_decide_at = INF;
                end
`endif
            end
        end
    endtask

    task automatic check_outputs();
        chk("req_ready", 32'(req_ready), 32'(m_run && !m_fault && (cyc >= m_idle_at)));
        chk("fsm_start", 32'(fsm_start), 32'(cyc == m_pulse_at));
        chk("fsm_load", 32'(fsm_load), 32'(m_load));
        chk("active_phase", 32'(active_phase), 32'(exp_active(cyc)));
        chk("busy", 32'(busy), 32'(m_fault || (cyc < m_idle_at)));
        chk("fault", 32'(fault), 32'(m_fault));
    endtask

    task automatic step(input logic v, input logic [1:0] ph, input logic sh, input logic clr);
        req_valid = v; req_phase = ph; fsm_short = sh; fault_clr = clr;
        @(posedge clk);
        cyc++;
        model_edge(v, ph, sh, clr, rst);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    initial begin
        int pulses;
        logic v, sh, clr;
        logic [1:0] ph;

        // Reset, then release
        rst = 1'b0;
        idle(2);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        rst = 1'b1;
        idle(1);
        chk("ready_after_release", 32'(req_ready), 32'd1);

        // Phase change to 1 with explicit timeline
        step(1'b1, 2'd1, 1'b0, 1'b0);
        chk("pc_start", 32'(fsm_start), 32'd1);
        chk("pc_load", 32'(fsm_load), 32'd1);
        chk("pc_busy", 32'(busy), 32'd1);
        idle(C - 1);
        chk("pc_active_pre", 32'(active_phase), 32'd0);
        idle(1);
        chk("pc_active", 32'(active_phase), 32'd1);
        idle(D - 1);
        chk("pc_ready_pre", 32'(req_ready), 32'd0);
        idle(1);
        chk("pc_ready", 32'(req_ready), 32'd1);

        // Change to 2, then same-phase request
        step(1'b1, 2'd2, 1'b0, 1'b0);
        idle(C + D);
        chk("ph2_active", 32'(active_phase), 32'd2);
        step(1'b1, 2'd2, 1'b0, 1'b0);
        chk("same_no_start", 32'(fsm_start), 32'd0);
        chk("same_busy", 32'(busy), 32'd0);
        chk("same_ready", 32'(req_ready), 32'd1);

        // Short during COMMUTE
        step(1'b1, 2'd3, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b1, 1'b0);
        chk("short_start", 32'(fsm_start), 32'd1);
        chk("short_load", 32'(fsm_load), 32'd0);
        chk("short_fault", 32'(fault), 32'd1);
        chk("short_active", 32'(active_phase), 32'd0);
        step(1'b0, 2'd0, 1'b1, 1'b0);
        chk("short_held_nopulse", 32'(fsm_start), 32'd0);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        chk("clr_fault", 32'(fault), 32'd0);
        chk("clr_ready", 32'(req_ready), 32'd1);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        chk("clr_idle_ignored", 32'(busy), 32'd0);

        // Simultaneous short and request in IDLE
        step(1'b1, 2'd1, 1'b1, 1'b0);
        chk("sim_fault", 32'(fault), 32'd1);
        chk("sim_start", 32'(fsm_start), 32'd1);
        chk("sim_ready", 32'(req_ready), 32'd0);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        idle(C + 2);
        chk("sim_not_accepted", 32'(active_phase), 32'd0);

`ifdef PHASE_SEQ_RETRY_EN
        // Single fault, short clears: saved phase reissued after cooldown
        step(1'b1, 2'd2, 1'b0, 1'b0);
        idle(C + D);
        step(1'b0, 2'd0, 1'b1, 1'b0);
        idle(CD);
        chk("retry_pre_start", 32'(fsm_start), 32'd0);
        idle(1);
        chk("retry_start", 32'(fsm_start), 32'd1);
        chk("retry_load", 32'(fsm_load), 32'd2);
        chk("retry_fault_low", 32'(fault), 32'd0);
        idle(C + D);
        chk("retry_active", 32'(active_phase), 32'd2);

        // Two failed cooldowns, third succeeds; next short locks out
        step(1'b0, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 2 * CD + 2; i++) step(1'b0, 2'd0, 1'b1, 1'b0);
        idle(CD);
        idle(1);
        chk("third_retry_start", 32'(fsm_start), 32'd1);
        step(1'b0, 2'd0, 1'b1, 1'b0);
        pulses = 0;
        for (int i = 0; i < CD + 5; i++) begin
            step(1'b0, 2'd0, 1'b0, 1'b0);
            if (fsm_start) pulses++;
        end
        chk("lockout_no_pulse", 32'(pulses), 32'd0);
        chk("lockout_fault", 32'(fault), 32'd1);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        chk("lockout_clr", 32'(fault), 32'd0);

        // Short held permanently: three cooldowns then lockout
        step(1'b0, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3 * CD + 3; i++) step(1'b0, 2'd0, 1'b1, 1'b0);
        pulses = 0;
        for (int i = 0; i < CD + 5; i++) begin
            step(1'b0, 2'd0, 1'b0, 1'b0);
            if (fsm_start) pulses++;
        end
        chk("held_lockout_no_pulse", 32'(pulses), 32'd0);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        chk("held_clr", 32'(req_ready), 32'd1);
`endif

        // Random traffic, with rare resets
        for (int i = 0; i < 600; i++) begin
            v   = 1'($urandom_range(0, 1));
            ph  = 2'($urandom_range(0, 3));
            sh  = ($urandom_range(0, 31) == 0);
            clr = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 199) != 0);
            step(v, ph, sh, clr);
        end
        rst = 1'b1;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
